// File: rtl/instr_encoder_pkg.sv
// Shared Y86-64 definitions for the instruction encoder and the fetch stage:
// icode constants, the "no register" code, encoder FSM states and the
// instruction length function. INSTR_ENCODER_HALT_STOP_EN adds the DONE state.
package instr_encoder_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1
`ifdef INSTR_ENCODER_HALT_STOP_EN
      ,
      ST_DONE = 2'd2
`endif
   } enc_state_e;

   // Encoded length in bytes; 0 marks an icode that is not a legal instruction.
   function automatic logic [3:0] instr_len(input logic [3:0] icode);
      case (icode)
         IHALT, INOP, IRET:               instr_len = 4'd1;
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    instr_len = 4'd2;
         IJXX, ICALL:                     instr_len = 4'd9;
         IIRMOVQ, IRMMOVQ, IMRMOVQ:       instr_len = 4'd10;
         default:                         instr_len = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-in / byte-out bus of the instruction encoder. The master side
// offers instructions and pointer loads; the slave side (the encoder) emits
// memory byte writes and status.
interface instr_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic [63:0] valC;
   logic        addr_load;
   logic [63:0] addr_in;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [63:0] next_pc;
   logic        busy;
   logic        instr_invalid;
   logic        mem_error;

   modport master (
      output in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in,
      input  in_ready, mem_we, mem_addr, mem_wdata, next_pc, busy,
             instr_invalid, mem_error
   );

   modport slave (
      input  in_valid, icode, ifun, rA, rB, valC, addr_load, addr_in,
      output in_ready, mem_we, mem_addr, mem_wdata, next_pc, busy,
             instr_invalid, mem_error
   );

endinterface

// File: rtl/instr_byte_mux.sv
// Picks byte number idx_i of the encoded instruction from the latched fields:
// opcode byte, register byte (with RNONE substitution) and little-endian valC.
module instr_byte_mux
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  icode_i,
   input  logic [3:0]  ifun_i,
   input  logic [3:0]  rA_i,
   input  logic [3:0]  rB_i,
   input  logic [63:0] valC_i,
   input  logic [3:0]  idx_i,
   output logic [7:0]  byte_o
);

   logic       regFmt;
   logic       hasValC;
   logic [3:0] valCFirst;
   logic [2:0] valCSel;
   logic [3:0] rAEff;
   logic [3:0] rBEff;

   // Classify the format, then route the requested byte position.
   always_comb begin
      regFmt    = 1'b0;
      hasValC   = 1'b0;
      valCFirst = 4'd0;
      valCSel   = 3'd0;
      rAEff     = rA_i;
      rBEff     = rB_i;
      byte_o    = 8'h00;

      case (icode_i)
         IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ: regFmt = 1'b1;
         default: regFmt = 1'b0;
      endcase

      case (icode_i)
         IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
            hasValC   = 1'b1;
            valCFirst = 4'd2;
         end
         IJXX, ICALL: begin
            hasValC   = 1'b1;
            valCFirst = 4'd1;
         end
         default: ;
      endcase

      if (icode_i == IIRMOVQ) rAEff = RNONE;
      if (icode_i == IPUSHQ || icode_i == IPOPQ) rBEff = RNONE;

      if (idx_i == 4'd0) begin
         byte_o = {icode_i, ifun_i};
      end else if (regFmt && idx_i == 4'd1) begin
         byte_o = {rAEff, rBEff};
      end else if (hasValC && idx_i >= valCFirst) begin
         valCSel = 3'(idx_i - valCFirst);
         byte_o  = valC_i[{valCSel, 3'b000} +: 8];
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder: accepts one instruction at a time and writes its
// bytes, one per cycle, to instruction memory at the write pointer.
// Optional feature macro INSTR_ENCODER_HALT_STOP_EN: after a halt byte the
// encoder parks in DONE until reset.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int MEM_SIZE = 4096
) (
   input  logic              clk,
   input  logic              rst,
   instr_encoder_if.slave    bus
);

   enc_state_e  state_q,     state_d;
   logic [63:0] ptr_q,       ptr_d;
   logic [3:0]  icode_q,     icode_d;
   logic [3:0]  ifun_q,      ifun_d;
   logic [3:0]  rA_q,        rA_d;
   logic [3:0]  rB_q,        rB_d;
   logic [63:0] valC_q,      valC_d;
   logic [3:0]  len_q,       len_d;
   logic [3:0]  idx_q,       idx_d;
   logic        invalid_q,   invalid_d;
   logic        memError_q,  memError_d;

   logic        accept;
   logic        inRange;
   logic        emitting;
   logic [7:0]  curByte;

   assign accept   = bus.in_valid && bus.in_ready;
   assign inRange  = ptr_q < 64'(MEM_SIZE);
   assign emitting = (state_q == ST_EMIT);

   instr_byte_mux u_mux (
      .icode_i (icode_q),
      .ifun_i  (ifun_q),
      .rA_i    (rA_q),
      .rB_i    (rB_q),
      .valC_i  (valC_q),
      .idx_i   (idx_q),
      .byte_o  (curByte)
   );

   // Next state: IDLE handles loads/acceptance, EMIT walks the bytes.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      icode_d    = icode_q;
      ifun_d     = ifun_q;
      rA_d       = rA_q;
      rB_d       = rB_q;
      valC_d     = valC_q;
      len_d      = len_q;
      idx_d      = idx_q;
      invalid_d  = 1'b0;
      memError_d = memError_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.addr_load) ptr_d = bus.addr_in;
            if (accept) begin
               if (instr_len(bus.icode) == 4'd0) begin
                  invalid_d = 1'b1;
               end else begin
                  icode_d = bus.icode;
                  ifun_d  = bus.ifun;
                  rA_d    = bus.rA;
                  rB_d    = bus.rB;
                  valC_d  = bus.valC;
                  len_d   = instr_len(bus.icode);
                  idx_d   = 4'd0;
                  state_d = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (!inRange) memError_d = 1'b1;
            ptr_d = ptr_q + 64'd1;
            idx_d = idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) begin
`ifdef INSTR_ENCODER_HALT_STOP_EN
               state_d = (icode_q == IHALT) ? ST_DONE : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef INSTR_ENCODER_HALT_STOP_EN
         ST_DONE: state_d = ST_DONE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any partial instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= 64'd0;
         icode_q    <= 4'd0;
         ifun_q     <= 4'd0;
         rA_q       <= 4'd0;
         rB_q       <= 4'd0;
         valC_q     <= 64'd0;
         len_q      <= 4'd0;
         idx_q      <= 4'd0;
         invalid_q  <= 1'b0;
         memError_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         icode_q    <= icode_d;
         ifun_q     <= ifun_d;
         rA_q       <= rA_d;
         rB_q       <= rB_d;
         valC_q     <= valC_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         invalid_q  <= invalid_d;
         memError_q <= memError_d;
      end
   end

   assign bus.in_ready      = (state_q == ST_IDLE) && !rst;
   assign bus.busy          = emitting;
   assign bus.mem_we        = emitting && inRange;
   assign bus.mem_addr      = ptr_q;
   assign bus.mem_wdata     = emitting ? curByte : 8'h00;
   assign bus.next_pc       = ptr_q;
   assign bus.instr_invalid = invalid_q;
   assign bus.mem_error     = memError_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed instructions push their hand-encoded bytes
// into a scoreboard queue; a negedge monitor pops one entry per emitted byte.
module tb_instr_encoder;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [7:0]  data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   logic [7:0] irmBytes  [10];
   logic [7:0] callBytes [9];
   logic [7:0] errBytes  [10];

   instr_encoder_if bus();

   instr_encoder #(.MEM_SIZE(4096)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic we, input logic [63:0] addr, input logic [7:0] data);
      exp_t e;
      e.we   = we;
      e.addr = addr;
      e.data = data;
      expQ.push_back(e);
   endtask

   // Scoreboard monitor: every busy cycle must match the next expected byte.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.mem_we && !bus.busy)
         checkOutput("we_outside_emit", 64'(bus.mem_we), 64'd0);
      if (!rst && bus.busy) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_byte: got addr %0h data %0h expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            e = expQ.pop_front();
            checkOutput("byte_we", 64'(bus.mem_we), 64'(e.we));
            checkOutput("byte_addr", bus.mem_addr, e.addr);
            if (e.we) checkOutput("byte_data", 64'(bus.mem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic driveFields(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic ld,
                              input logic [63:0] la, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL ready_timeout: got in_ready 0 expected 1");
         return;
      end
      bus.in_valid  = 1'b1;
      bus.icode     = ic;
      bus.ifun      = fn;
      bus.rA        = ra;
      bus.rB        = rb;
      bus.valC      = vc;
      bus.addr_load = ld;
      bus.addr_in   = la;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.addr_load = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input logic ld,
                                input logic [63:0] la, output int low,
                                output logic sawInvalid);
      logic ok;
      low        = 0;
      sawInvalid = 1'b0;
      driveFields(ic, fn, ra, rb, vc, ld, la, ok);
      if (!ok) return;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) sawInvalid = bus.instr_invalid;
         if (bus.in_ready) break;
         low++;
      end
   endtask

   task automatic loadAddr(input logic [63:0] a);
      @(negedge clk);
      bus.addr_load = 1'b1;
      bus.addr_in   = a;
      @(posedge clk);
      #1;
      bus.addr_load = 1'b0;
   endtask

   initial begin
      int   low;
      logic inv;
      logic ok;
      logic [63:0] pcBefore;

      irmBytes  = '{8'h30, 8'hf4, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      callBytes = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      errBytes  = '{8'h30, 8'hf4, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.icode     = 4'h0;
      bus.ifun      = 4'h0;
      bus.rA        = 4'h0;
      bus.rB        = 4'h0;
      bus.valC      = 64'd0;
      bus.addr_load = 1'b0;
      bus.addr_in   = 64'd0;

      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_mem_we", 64'(bus.mem_we), 64'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 64'd0);
      checkOutput("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      checkOutput("rst_next_pc", bus.next_pc, 64'd0);
      checkOutput("rst_invalid", 64'(bus.instr_invalid), 64'd0);
      checkOutput("rst_mem_error", 64'(bus.mem_error), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);

      $display("[TB] irmovq $0x100,%%rsp at 0");
      for (int i = 0; i < 10; i++) pushExp(1'b1, 64'(i), irmBytes[i]);
      applyStimulus(4'h3, 4'h0, 4'h0, 4'h4, 64'h100, 1'b0, 64'd0, low, inv);
      checkOutput("irmovq_low_cycles", 64'(low), 64'd10);
      checkOutput("irmovq_next_pc", bus.next_pc, 64'd10);
      checkOutput("irmovq_drained", 64'(expQ.size()), 64'd0);
      checkOutput("irmovq_no_invalid", 64'(inv), 64'd0);

      $display("[TB] addr_load 20, call 0x40");
      loadAddr(64'd20);
      for (int i = 0; i < 9; i++) pushExp(1'b1, 64'(20 + i), callBytes[i]);
      applyStimulus(4'h8, 4'h0, 4'h0, 4'h0, 64'h40, 1'b0, 64'd0, low, inv);
      checkOutput("call_low_cycles", 64'(low), 64'd9);
      checkOutput("call_next_pc", bus.next_pc, 64'd29);

      $display("[TB] burst OPq, pushq, ret");
      pushExp(1'b1, 64'd29, 8'h60);
      pushExp(1'b1, 64'd30, 8'h23);
      pushExp(1'b1, 64'd31, 8'ha0);
      pushExp(1'b1, 64'd32, 8'h5f);
      pushExp(1'b1, 64'd33, 8'h90);
      applyStimulus(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("opq_low_cycles", 64'(low), 64'd2);
      applyStimulus(4'hA, 4'h0, 4'h5, 4'h0, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("pushq_low_cycles", 64'(low), 64'd2);
      applyStimulus(4'h9, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("ret_low_cycles", 64'(low), 64'd1);
      checkOutput("burst_next_pc", bus.next_pc, 64'd34);

      $display("[TB] illegal icode 0xC");
      pcBefore = bus.next_pc;
      applyStimulus(4'hC, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("invalid_low_cycles", 64'(low), 64'd0);
      checkOutput("invalid_pulse", 64'(inv), 64'd1);
      @(negedge clk);
      checkOutput("invalid_pulse_end", 64'(bus.instr_invalid), 64'd0);
      checkOutput("invalid_next_pc", bus.next_pc, 64'd34);
      checkOutput("invalid_pc_kept", bus.next_pc, pcBefore);

      $display("[TB] addr_load with acceptance");
      pushExp(1'b1, 64'd200, 8'h90);
      applyStimulus(4'h9, 4'h0, 4'h0, 4'h0, 64'd0, 1'b1, 64'd200, low, inv);
      checkOutput("loadaccept_low_cycles", 64'(low), 64'd1);
      checkOutput("loadaccept_next_pc", bus.next_pc, 64'd201);

      $display("[TB] addr_load ignored during emission");
      pushExp(1'b1, 64'd201, 8'h60);
      pushExp(1'b1, 64'd202, 8'h23);
      driveFields(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 1'b0, 64'd0, ok);
      bus.addr_load = 1'b1;
      bus.addr_in   = 64'd500;
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.addr_load = 1'b0;
      @(negedge clk);
      checkOutput("emitload_next_pc", bus.next_pc, 64'd203);

      $display("[TB] out-of-range irmovq at 4094");
      checkOutput("mem_error_clear", 64'(bus.mem_error), 64'd0);
      loadAddr(64'd4094);
      for (int i = 0; i < 10; i++)
         pushExp((4094 + i) < 4096, 64'(4094 + i), errBytes[i]);
      applyStimulus(4'h3, 4'h0, 4'h0, 4'h4, 64'h1122334455667788, 1'b0, 64'd0, low, inv);
      checkOutput("range_low_cycles", 64'(low), 64'd10);
      checkOutput("range_mem_error", 64'(bus.mem_error), 64'd1);
      checkOutput("range_next_pc", bus.next_pc, 64'd4104);

      $display("[TB] reset during irmovq");
      loadAddr(64'd300);
      pushExp(1'b1, 64'd300, 8'h30);
      pushExp(1'b1, 64'd301, 8'hf4);
      pushExp(1'b1, 64'd302, 8'h00);
      driveFields(4'h3, 4'h0, 4'h0, 4'h4, 64'h100, 1'b0, 64'd0, ok);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre_rst_mem_we", 64'(bus.mem_we), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_mem_we", 64'(bus.mem_we), 64'd0);
      checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
      checkOutput("midrst_next_pc", bus.next_pc, 64'd0);
      checkOutput("midrst_mem_error", 64'(bus.mem_error), 64'd0);
      checkOutput("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("midrst_drained", 64'(expQ.size()), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_ready_after", 64'(bus.in_ready), 64'd1);

`ifdef INSTR_ENCODER_HALT_STOP_EN
      $display("[TB] halt parks the encoder");
      pushExp(1'b1, 64'd0, 8'h00);
      driveFields(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, ok);
      low = 0;
      bus.addr_load = 1'b1;
      bus.addr_in   = 64'd77;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.in_ready) low++;
      end
      bus.addr_load = 1'b0;
      checkOutput("halt_ready_high_cycles", 64'(low), 64'd0);
      checkOutput("halt_next_pc", bus.next_pc, 64'd1);
`else
      $display("[TB] halt as ordinary instruction");
      pushExp(1'b1, 64'd0, 8'h00);
      pushExp(1'b1, 64'd1, 8'h10);
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("halt_low_cycles", 64'(low), 64'd1);
      applyStimulus(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, low, inv);
      checkOutput("nop_low_cycles", 64'(low), 64'd1);
      checkOutput("halt_next_pc", bus.next_pc, 64'd2);
`endif

      @(negedge clk);
      checkOutput("final_drained", 64'(expQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
